// File: rtl/mbus_ice_tx_framer.sv
// mbus_ice_tx_framer: ICE byte stream to MBus master transmit framer.
// Collects a short (1 byte) or long (4 byte, first nibble F) address and one or
// more DATA_BYTES-wide data words, then runs the txreq/txack/succ/fail handshake
// and reports the outcome as a single tx_gen_ack or tx_gen_nak pulse.
// Optional response timeout: define MBUS_ICE_TX_TIMEOUT_EN.
module mbus_ice_tx_framer #(
   parameter int DATA_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tx_frame_valid,
   input  logic                    tx_char_valid,
   input  logic [7:0]              tx_char,
   input  logic                    tx_char_pending,
   output logic                    tx_char_advance,
   output logic [31:0]             tx_mbus_txaddr,
   output logic [8*DATA_BYTES-1:0] tx_mbus_txdata,
   output logic                    tx_mbus_txreq,
   output logic                    tx_mbus_txpend,
   input  logic                    tx_mbus_txack,
   input  logic                    tx_mbus_txsucc,
   input  logic                    tx_mbus_txfail,
   output logic                    tx_mbus_txresp_ack,
   output logic                    tx_gen_ack,
   output logic                    tx_gen_nak,
   input  logic                    tx_acknak_valid,
   output logic                    tx_busy
);

   localparam int         DW    = 8 * DATA_BYTES;
   localparam logic [1:0] DLAST = 2'(DATA_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_WAIT, S_TXREQ, S_TXACK, S_TXSUCC, S_RESULT
   } state_t;

   state_t         state, state_nx;
   logic [1:0]     bcnt, bcnt_nx;
   logic           alng, alng_nx;
   logic [31:0]    addr_nx;
   logic [DW-1:0]  data_nx;
   logic [DW+7:0]  data_shift;
   logic           first_long;
   logic           tmo_clr;
   logic           tmo_hit;

   // State, counter and assembled address/data registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         bcnt           <= '0;
         alng           <= 1'b0;
         tx_mbus_txaddr <= '0;
         tx_mbus_txdata <= '0;
      end else begin
         state          <= state_nx;
         bcnt           <= bcnt_nx;
         alng           <= alng_nx;
         tx_mbus_txaddr <= addr_nx;
         tx_mbus_txdata <= data_nx;
      end
   end

   // Next-state, byte assembly and handshake output decode
   always_comb begin
      state_nx           = state;
      bcnt_nx            = bcnt;
      alng_nx            = alng;
      addr_nx            = tx_mbus_txaddr;
      data_nx            = tx_mbus_txdata;
      tx_char_advance    = 1'b0;
      tx_mbus_txreq      = 1'b0;
      tx_mbus_txpend     = 1'b0;
      tx_mbus_txresp_ack = 1'b0;
      tx_gen_ack         = 1'b0;
      tx_gen_nak         = 1'b0;
      tmo_clr            = 1'b0;
      tx_busy            = (state != S_IDLE);
      // Shifting through a DW+8 window keeps DATA_BYTES=1 free of negative slices
      data_shift         = {tx_mbus_txdata, tx_char};
      first_long         = (tx_char[7:4] == 4'hF);

      case (state)
         S_IDLE: begin
            if (tx_frame_valid) begin
               state_nx = S_ADDR;
               bcnt_nx  = '0;
               alng_nx  = 1'b0;
               addr_nx  = '0;
            end
         end
         S_ADDR: begin
            if (!tx_frame_valid) begin
               tx_gen_nak = 1'b1;
               state_nx   = S_RESULT;
            end else if (tx_char_valid) begin
               tx_char_advance = 1'b1;
               addr_nx = {tx_mbus_txaddr[23:0], tx_char};
               bcnt_nx = bcnt + 2'd1;
               if (bcnt == 2'd0) alng_nx = first_long;
               // Length is decided by the first byte itself, before alng is registered
               if ((bcnt == 2'd0) ? !first_long : (bcnt == 2'd3)) begin
                  state_nx = S_DATA;
                  bcnt_nx  = '0;
               end
            end
         end
         S_DATA: begin
            if (!tx_frame_valid) begin
               tx_gen_nak = 1'b1;
               state_nx   = S_RESULT;
            end else if (tx_char_valid) begin
               tx_char_advance = 1'b1;
               data_nx = data_shift[DW-1:0];
               bcnt_nx = bcnt + 2'd1;
               if (bcnt == DLAST) begin
                  state_nx = S_WAIT;
                  bcnt_nx  = '0;
               end
            end
         end
         S_WAIT: begin
            state_nx = S_TXREQ;
            tmo_clr  = 1'b1;
         end
         S_TXREQ: begin
            tx_mbus_txreq  = 1'b1;
            tx_mbus_txpend = tx_char_pending;
            if (tx_mbus_txack) begin
               state_nx = S_TXACK;
            end else if (tmo_hit) begin
               tx_gen_nak = 1'b1;
               state_nx   = S_RESULT;
            end
         end
         S_TXACK: begin
            if (!tx_mbus_txack) begin
               if (tx_char_pending) begin
                  state_nx = S_DATA;
                  bcnt_nx  = '0;
               end else begin
                  state_nx = S_TXSUCC;
                  tmo_clr  = 1'b1;
               end
            end
         end
         S_TXSUCC: begin
            if (tx_mbus_txsucc) begin
               tx_gen_ack = 1'b1;
               state_nx   = S_RESULT;
            end else if (tx_mbus_txfail || tmo_hit) begin
               tx_gen_nak = 1'b1;
               state_nx   = S_RESULT;
            end
         end
         S_RESULT: begin
            tx_mbus_txresp_ack = 1'b1;
            if (!tx_acknak_valid) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef MBUS_ICE_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;

   // Response timeout counter, restarted on entry to TXREQ and TXSUCC
   always_ff @(posedge clk) begin
      if (!reset_n)
         tcnt <= '0;
      else if (tmo_clr)
         tcnt <= '0;
      else if (state == S_TXREQ || state == S_TXSUCC)
         tcnt <= tcnt + 1'b1;
   end

   // Expiry on the last allowed cycle so txreq is held exactly TIMEOUT_CYCLES cycles
   assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^{tmo_clr, TIMEOUT_CYCLES};
`endif

endmodule
